// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry registered valid/ready slot for the 2:1 mux stage.
// Optional grant statistics are compiled in when MUX_ARB_STATS_EN is defined.
module mux_rr_arbiter #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_nx;
    logic   last;
    logic   load;
    logic   grant_b;

    // On a tie the channel that did not win last time is granted.
    always_comb begin
        load    = (a_valid | b_valid) & ((state == EMPTY) | out_ready) & ~rst;
        grant_b = b_valid & (~a_valid | ~last);
        a_ready = load & ~grant_b;
        b_ready = load & grant_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (load) state_nx = FULL;
            FULL:  if (out_ready && !load) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            sel      <= 1'b0;
            last     <= 1'b1;
        end else if (load) begin
            out_data <= grant_b ? b_data : a_data;
            sel      <= grant_b;
            last     <= grant_b;
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] a_cnt_q, b_cnt_q;

    // Saturating handshake counters; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            if (a_ready && a_cnt_q != '1) a_cnt_q <= a_cnt_q + CNT_W'(1);
            if (b_ready && b_cnt_q != '1) b_cnt_q <= b_cnt_q + CNT_W'(1);
        end
    end

    assign a_count = a_cnt_q;
    assign b_count = b_cnt_q;
`else
    assign a_count = '0;
    assign b_count = '0;
`endif

endmodule
